// File: rtl/scm_2w_write_ctrl.sv
// Two-producer write front end for the 2R/2W latch SCM: per-port FIFOs, fair same-address serialisation, read bypass.
// Latency: push at edge T -> we_x_o high in the cycle after edge T+1; bypass paths are combinational.
// Backpressure: ready_o = FIFO not full (registered count); optional SCM_WCTRL_BYPASS_EN builds stage D + forwarding.
module scm_2w_write_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a_valid_i,
    output logic                  req_a_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_a_addr_i,
    input  logic [DATA_WIDTH-1:0] req_a_data_i,
    input  logic                  req_b_valid_i,
    output logic                  req_b_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_b_addr_i,
    input  logic [DATA_WIDTH-1:0] req_b_data_i,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_a_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_b_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
    output logic                  idle_o
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    // Index 0 is producer/port A, index 1 is producer/port B throughout.
    logic [EW-1:0]         mem_q   [2][FIFO_DEPTH];
    logic [PW-1:0]         wptr_q  [2];
    logic [PW-1:0]         rptr_q  [2];
    logic [CW-1:0]         cnt_q   [2];
    logic [CW-1:0]         cnt_d   [2];
    logic [EW-1:0]         req_ent [2];
    logic [EW-1:0]         head_ent[2];
    logic [1:0]            req_vld;
    logic [1:0]            rdy;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            head_vld;
    logic                  collide;
    logic                  prio_q;
    logic                  prio_d;
    logic [1:0]            we_q;
    logic [ADDR_WIDTH-1:0] waddr_q[2];
    logic [DATA_WIDTH-1:0] wdata_q[2];
    logic [ADDR_WIDTH-1:0] raddr  [2];
    logic [DATA_WIDTH-1:0] rf_rdata[2];
    logic [DATA_WIDTH-1:0] rdata  [2];

    always_comb begin
        req_vld    = {req_b_valid_i, req_a_valid_i};
        req_ent[0] = {req_a_addr_i, req_a_data_i};
        req_ent[1] = {req_b_addr_i, req_b_data_i};
        for (int p = 0; p < 2; p++) begin
            rdy[p]      = (cnt_q[p] != CW'(FIFO_DEPTH));
            push[p]     = req_vld[p] && rdy[p];
            head_vld[p] = (cnt_q[p] != '0);
            head_ent[p] = mem_q[p][rptr_q[p]];
        end
        // Equal-address heads: the prioritised side issues alone and priority flips.
        collide = head_vld[0] && head_vld[1] &&
                  (head_ent[0][EW-1:DATA_WIDTH] == head_ent[1][EW-1:DATA_WIDTH]);
        pop[0]  = head_vld[0] && !(collide && prio_q);
        pop[1]  = head_vld[1] && !(collide && !prio_q);
        prio_d  = collide ? !prio_q : prio_q;
        for (int p = 0; p < 2; p++) begin
            cnt_d[p] = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) mem_q[p][wptr_q[p]] <= req_ent[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                cnt_q[p]   <= '0;
                wptr_q[p]  <= '0;
                rptr_q[p]  <= '0;
                waddr_q[p] <= '0;
                wdata_q[p] <= '0;
            end
            we_q   <= '0;
            prio_q <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                cnt_q[p] <= cnt_d[p];
                if (push[p]) wptr_q[p] <= wptr_q[p] + 1'b1;
                if (pop[p]) begin
                    rptr_q[p]  <= rptr_q[p] + 1'b1;
                    waddr_q[p] <= head_ent[p][EW-1:DATA_WIDTH];
                    wdata_q[p] <= head_ent[p][DATA_WIDTH-1:0];
                end
            end
            we_q   <= pop;
            prio_q <= prio_d;
        end
    end

    assign raddr[0]    = raddr_a_i;
    assign raddr[1]    = raddr_b_i;
    assign rf_rdata[0] = rf_rdata_a_i;
    assign rf_rdata[1] = rf_rdata_b_i;

`ifdef SCM_WCTRL_BYPASS_EN
    // Stage D mirrors the issue regs one cycle later, covering the latch-open window.
    logic [1:0]            dv_q;
    logic [ADDR_WIDTH-1:0] daddr_q[2];
    logic [DATA_WIDTH-1:0] ddata_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q <= '0;
            for (int p = 0; p < 2; p++) begin
                daddr_q[p] <= '0;
                ddata_q[p] <= '0;
            end
        end else begin
            dv_q <= we_q;
            for (int p = 0; p < 2; p++) begin
                daddr_q[p] <= waddr_q[p];
                ddata_q[p] <= wdata_q[p];
            end
        end
    end

    // Later assignments win: I.b > I.a > D.b > D.a > array.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rdata[r] = rf_rdata[r];
            if (dv_q[0] && (daddr_q[0] == raddr[r])) rdata[r] = ddata_q[0];
            if (dv_q[1] && (daddr_q[1] == raddr[r])) rdata[r] = ddata_q[1];
            if (we_q[0] && (waddr_q[0] == raddr[r])) rdata[r] = wdata_q[0];
            if (we_q[1] && (waddr_q[1] == raddr[r])) rdata[r] = wdata_q[1];
        end
    end
`else
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rdata[r] = rf_rdata[r];
        end
    end
`endif

    assign req_a_ready_o = rdy[0];
    assign req_b_ready_o = rdy[1];
    assign we_a_o        = we_q[0];
    assign waddr_a_o     = waddr_q[0];
    assign wdata_a_o     = wdata_q[0];
    assign we_b_o        = we_q[1];
    assign waddr_b_o     = waddr_q[1];
    assign wdata_b_o     = wdata_q[1];
    assign rf_raddr_a_o  = raddr_a_i;
    assign rf_raddr_b_o  = raddr_b_i;
    assign rdata_a_o     = rdata[0];
    assign rdata_b_o     = rdata[1];
    assign idle_o        = (cnt_q[0] == '0) && (cnt_q[1] == '0) && (we_q == 2'b00);

endmodule

// File: tb/tb_scm_2w_write_ctrl.sv
// Bench for scm_2w_write_ctrl: directed tables and sequences plus random traffic against a queue-based model.
module tb_scm_2w_write_ctrl;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a_valid_i = 1'b0, req_b_valid_i = 1'b0;
    logic          req_a_ready_o, req_b_ready_o;
    logic [AW-1:0] req_a_addr_i = '0, req_b_addr_i = '0;
    logic [DW-1:0] req_a_data_i = '0, req_b_data_i = '0;
    logic          we_a_o, we_b_o;
    logic [AW-1:0] waddr_a_o, waddr_b_o;
    logic [DW-1:0] wdata_a_o, wdata_b_o;
    logic [AW-1:0] raddr_a_i = '0, raddr_b_i = '0;
    logic [DW-1:0] rdata_a_o, rdata_b_o;
    logic [AW-1:0] rf_raddr_a_o, rf_raddr_b_o;
    logic [DW-1:0] rf_rdata_a_i = '0, rf_rdata_b_i = '0;
    logic          idle_o;

    always #5 clk = ~clk;

    scm_2w_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_a_valid_i(req_a_valid_i), .req_a_ready_o(req_a_ready_o),
        .req_a_addr_i(req_a_addr_i), .req_a_data_i(req_a_data_i),
        .req_b_valid_i(req_b_valid_i), .req_b_ready_o(req_b_ready_o),
        .req_b_addr_i(req_b_addr_i), .req_b_data_i(req_b_data_i),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
        .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_rdata_a_i(rf_rdata_a_i),
        .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o),
        .rf_raddr_b_o(rf_raddr_b_o), .rf_rdata_b_i(rf_rdata_b_i),
        .idle_o(idle_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          va;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          vb;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        logic          ewa;
        logic [AW-1:0] eaa;
        logic [DW-1:0] eda;
        logic          ewb;
        logic [AW-1:0] eab;
        logic [DW-1:0] edb;
        logic          eidle;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-producer queues, issue (I) and delay (D) slots, the RF content readers see.
    wr_t           qa[$], qb[$];
    logic          mi_vld[2], md_vld[2];
    wr_t           mi[2], md[2];
    logic          mprio;
    logic [DW-1:0] rf_vis[2**AW];
    logic          last_acc_a, last_acc_b;
    logic [DW-1:0] obs_b[$];
    int            issued3;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] r);
`ifdef SCM_WCTRL_BYPASS_EN
        if (mi_vld[1] && mi[1].addr == r) return mi[1].data;
        if (mi_vld[0] && mi[0].addr == r) return mi[0].data;
        if (md_vld[1] && md[1].addr == r) return md[1].data;
        if (md_vld[0] && md[0].addr == r) return md[0].data;
`endif
        return rf_vis[r];
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int p = 0; p < 2; p++) begin
            mi_vld[p] = 1'b0;
            md_vld[p] = 1'b0;
        end
        mprio = 1'b0;
    endtask

    task automatic model_step();
        logic acc_a, acc_b, ha, hb, coll, pa, pb;
        acc_a = req_a_valid_i && (qa.size() < DEPTH);
        acc_b = req_b_valid_i && (qb.size() < DEPTH);
        ha    = (qa.size() > 0);
        hb    = (qb.size() > 0);
        coll  = 1'b0;
        if (ha && hb) coll = (qa[0].addr == qb[0].addr);
        pa = ha && !(coll && mprio);
        pb = hb && !(coll && !mprio);
        for (int p = 0; p < 2; p++) begin
            if (md_vld[p]) rf_vis[md[p].addr] = md[p].data;
        end
        md_vld = mi_vld;
        md     = mi;
        mi_vld[0] = pa;
        mi_vld[1] = pb;
        if (pa) mi[0] = qa.pop_front();
        if (pb) mi[1] = qb.pop_front();
        if (coll) mprio = !mprio;
        if (acc_a) qa.push_back({req_a_addr_i, req_a_data_i});
        if (acc_b) qb.push_back({req_b_addr_i, req_b_data_i});
        last_acc_a = acc_a;
        last_acc_b = acc_b;
    endtask

    task automatic check_cycle();
        chk("we_a", {31'd0, we_a_o}, {31'd0, mi_vld[0]});
        if (mi_vld[0]) begin
            chk("waddr_a", {27'd0, waddr_a_o}, {27'd0, mi[0].addr});
            chk("wdata_a", wdata_a_o, mi[0].data);
        end
        chk("we_b", {31'd0, we_b_o}, {31'd0, mi_vld[1]});
        if (mi_vld[1]) begin
            chk("waddr_b", {27'd0, waddr_b_o}, {27'd0, mi[1].addr});
            chk("wdata_b", wdata_b_o, mi[1].data);
        end
        chk("ready_a", {31'd0, req_a_ready_o}, {31'd0, qa.size() < DEPTH});
        chk("ready_b", {31'd0, req_b_ready_o}, {31'd0, qb.size() < DEPTH});
        chk("idle", {31'd0, idle_o},
            {31'd0, (qa.size() == 0) && (qb.size() == 0) && !mi_vld[0] && !mi_vld[1]});
        chk("rdata_a", rdata_a_o, exp_rd(raddr_a_i));
        chk("rdata_b", rdata_b_o, exp_rd(raddr_b_i));
        chk("rf_raddr_a", {27'd0, rf_raddr_a_o}, {27'd0, raddr_a_i});
        chk("dual_same_addr", {31'd0, we_a_o && we_b_o && (waddr_a_o == waddr_b_o)}, 32'd0);
    endtask

    // Called at a negedge: drive inputs, advance the model at the edge, check at the next negedge.
    task automatic cycle(input logic va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic vb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        req_a_valid_i = va; req_a_addr_i = aa; req_a_data_i = da;
        req_b_valid_i = vb; req_b_addr_i = ab; req_b_data_i = db;
        raddr_a_i = ra; raddr_b_i = rb;
        rf_rdata_a_i = rf_vis[ra];
        rf_rdata_b_i = rf_vis[rb];
        @(posedge clk);
        model_step();
        rf_rdata_a_i = rf_vis[ra];
        rf_rdata_b_i = rf_vis[rb];
        @(negedge clk);
        check_cycle();
        if (we_b_o) obs_b.push_back(wdata_b_o);
        if ((we_a_o && waddr_a_o == 5'h03) || (we_b_o && waddr_b_o == 5'h03)) issued3++;
    endtask

    task automatic do_reset();
        req_a_valid_i = 1'b0;
        req_b_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_we_a", {31'd0, we_a_o}, 32'd0);
        chk("rst_waddr_a", {27'd0, waddr_a_o}, 32'd0);
        chk("rst_wdata_a", wdata_a_o, 32'd0);
        chk("rst_we_b", {31'd0, we_b_o}, 32'd0);
        chk("rst_wdata_b", wdata_b_o, 32'd0);
        chk("rst_ready_a", {31'd0, req_a_ready_o}, 32'd1);
        chk("rst_ready_b", {31'd0, req_b_ready_o}, 32'd1);
        chk("rst_idle", {31'd0, idle_o}, 32'd1);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t tbl[8];

    initial begin
        int ka, kb;
        logic saw_low;
        for (int i = 0; i < 2**AW; i++) rf_vis[i] = 32'h5000_0000 + i;
        model_reset();
        tbl[0] = '{1, 5'h01, 32'hAAAA0001, 1, 5'h02, 32'hBBBB0002, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 1, 5'h01, 32'hAAAA0001, 1, 5'h02, 32'hBBBB0002, 0};
        tbl[2] = '{1, 5'h05, 32'h000000A0, 1, 5'h05, 32'h000000B0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 5'h05, 32'h000000A1, 1, 5'h05, 32'h000000B1, 1, 5'h05, 32'h000000A0, 0, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'h05, 32'h000000B0, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 5'h05, 32'h000000A1, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'h05, 32'h000000B1, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        // Reset mid-burst
        do_reset();
        cycle(1, 5'h01, 32'h0000_0101, 0, 0, 0, 0, 0);
        cycle(1, 5'h02, 32'h0000_0102, 0, 0, 0, 0, 0);
        cycle(1, 5'h03, 32'h0000_0103, 0, 0, 0, 0, 0);
        req_a_valid_i = 1'b0;
        issued3 = 0;
        rst = 1'b1;
        #1;
        chk("midrst_we_a", {31'd0, we_a_o}, 32'd0);
        chk("midrst_we_b", {31'd0, we_b_o}, 32'd0);
        chk("midrst_ready_a", {31'd0, req_a_ready_o}, 32'd1);
        chk("midrst_idle", {31'd0, idle_o}, 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("no_write_0x03", 32'(issued3), 32'd0);

        // Dual issue and collision fairness
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].va, tbl[i].aa, tbl[i].da, tbl[i].vb, tbl[i].ab, tbl[i].db, 0, 0);
            chk($sformatf("tbl%0d_we_a", i), {31'd0, we_a_o}, {31'd0, tbl[i].ewa});
            chk($sformatf("tbl%0d_we_b", i), {31'd0, we_b_o}, {31'd0, tbl[i].ewb});
            if (tbl[i].ewa) begin
                chk($sformatf("tbl%0d_waddr_a", i), {27'd0, waddr_a_o}, {27'd0, tbl[i].eaa});
                chk($sformatf("tbl%0d_wdata_a", i), wdata_a_o, tbl[i].eda);
            end
            if (tbl[i].ewb) begin
                chk($sformatf("tbl%0d_waddr_b", i), {27'd0, waddr_b_o}, {27'd0, tbl[i].eab});
                chk($sformatf("tbl%0d_wdata_b", i), wdata_b_o, tbl[i].edb);
            end
            chk($sformatf("tbl%0d_idle", i), {31'd0, idle_o}, {31'd0, tbl[i].eidle});
        end

        // Backpressure: B streams into a sink halved by collisions with A
        do_reset();
        ka = 0; kb = 0; saw_low = 1'b0;
        obs_b.delete();
        for (int c = 0; c < 80; c++) begin
            if (ka >= 16 && kb >= 8 && idle_o) break;
            cycle(ka < 16, 5'h07, 32'hA400_0000 + ka, kb < 8, 5'h07, 32'hB400_0000 + kb, 0, 0);
            if (last_acc_a) ka++;
            if (last_acc_b) kb++;
            if (!req_b_ready_o && !saw_low) begin
                saw_low = 1'b1;
                chk("bp_occupancy_at_ready_low", 32'(kb - obs_b.size()), DEPTH);
            end
        end
        chk("bp_ready_b_went_low", {31'd0, saw_low}, 32'd1);
        chk("bp_accepted_b", 32'(kb), 32'd8);
        chk("bp_drained_idle", {31'd0, idle_o}, 32'd1);
        chk("bp_issued_b_count", 32'(obs_b.size()), 32'd8);
        for (int k = 0; k < obs_b.size() && k < 8; k++)
            chk($sformatf("bp_order_b%0d", k), obs_b[k], 32'hB400_0000 + k);

        // Read forwarding around a single write
        do_reset();
        rf_vis[31] = 32'h1111_1111;
        cycle(1, 5'h1F, 32'hDEAD_BEEF, 0, 0, 0, 5'h1F, 5'h1F);
        cycle(0, 0, 0, 0, 0, 0, 5'h1F, 5'h1F);
        chk("fwd_issue_we_a", {31'd0, we_a_o}, 32'd1);
`ifdef SCM_WCTRL_BYPASS_EN
        chk("fwd_issue_rdata_a", rdata_a_o, 32'hDEAD_BEEF);
`else
        chk("fwd_issue_rdata_a", rdata_a_o, 32'h1111_1111);
`endif
        cycle(0, 0, 0, 0, 0, 0, 5'h1F, 5'h1F);
`ifdef SCM_WCTRL_BYPASS_EN
        chk("fwd_delay_rdata_a", rdata_a_o, 32'hDEAD_BEEF);
`else
        chk("fwd_delay_rdata_a", rdata_a_o, 32'h1111_1111);
`endif
        cycle(0, 0, 0, 0, 0, 0, 5'h1F, 5'h1F);
        chk("fwd_latched_rdata_a", rdata_a_o, 32'hDEAD_BEEF);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [AW-1:0] aa, ab;
            aa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            ab = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            cycle($urandom_range(0, 9) < 7, aa, $urandom,
                  $urandom_range(0, 9) < 7, ab, $urandom,
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
        end
        for (int c = 0; c < 20; c++) cycle(0, 0, 0, 0, 0, 0, AW'(c), AW'(c + 1));
        chk("rand_drained_idle", {31'd0, idle_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
